usr_shift_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the universal shift register (usr) and drives its ctrl and d inputs.
- Accepts one shift command per valid/ready handshake: parallel data, shift direction, shift count.
- Issues one load cycle followed by the requested number of shift cycles.
- Captures the register's q output as a result, with a one-cycle done pulse.
- Replaces hand-driven ctrl/d sequences with a deterministic, countable protocol.

---
 rtl/usr_shift_sequencer.sv | 172 +++++++++++++++++
 tb/tb_usr_shift_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer
//
// Command sequencer for the universal shift register (usr). It sits directly
// upstream of the usr and drives its ctrl and d inputs. Each accepted command
// produces one parallel-load cycle, then the requested number of shift cycles,
// then one capture cycle. The capture cycle samples the usr output into result.
//
// Ports:
//   clk        rising-edge clock, shared with the usr
//   rst        synchronous reset, active-high
//   cmd_valid  command present
//   cmd_ready  sequencer can accept a command (IDLE and not in reset)
//   cmd_dir    0 = right shift, 1 = left shift
//   cmd_data   value to parallel-load into the usr
//   cmd_count  number of shift cycles; values above N clamp to N
//   ctrl       to usr ctrl: 00 hold, 01 right, 10 left, 11 load
//   d          to usr d
//   q_in       from usr q
//   result     q_in captured after the final shift; holds until the next done
//   busy       high while a command is in progress
//   done       one-cycle pulse, result valid from that cycle

module usr_shift_sequencer #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [N-1:0]     cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       ctrl,
  output logic [N-1:0]     d,
  input  logic [N-1:0]     q_in,
  output logic [N-1:0]     result,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] CTRL_HOLD  = 2'b00;
  localparam logic [1:0] CTRL_RIGHT = 2'b01;
  localparam logic [1:0] CTRL_LEFT  = 2'b10;
  localparam logic [1:0] CTRL_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SHIFT   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [N-1:0]     data_q;
  logic             dir_q;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] count_clamped;
  logic             accept;

  // Oversized counts saturate at N, since more than N shifts cannot change
  // a zero-filled N-bit register any further.
  assign count_clamped = (cmd_count > N_CNT) ? N_CNT : cmd_count;

  assign accept = cmd_valid & cmd_ready;

  // State register. Reset from any state aborts the command silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode. ctrl and d depend only on the registered
  // state and the latched command, so nothing on cmd_* reaches the usr
  // combinationally. cmd_ready is the only output that sees rst directly:
  // it has to stay low while reset is asserted.
  always_comb begin
    state_next = state;
    ctrl       = CTRL_HOLD;
    d          = '0;
    busy       = 1'b0;
    cmd_ready  = 1'b0;

    unique case (state)
      IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid && !rst) begin
          state_next = LOAD;
        end
      end

      LOAD: begin
        ctrl = CTRL_LOAD;
        d    = data_q;
        busy = 1'b1;
        if (remaining != '0) begin
          state_next = SHIFT;
        end else begin
          state_next = CAPTURE;
        end
      end

      SHIFT: begin
        ctrl = dir_q ? CTRL_LEFT : CTRL_RIGHT;
        d    = data_q;
        busy = 1'b1;
        // remaining counts the shift cycles still owed, including this one.
        // The <= also covers a zero count, which should never reach SHIFT.
        if (remaining <= CNT_W'(1)) begin
          state_next = CAPTURE;
        end
      end

      CAPTURE: begin
        ctrl       = CTRL_HOLD;
        d          = data_q;
        busy       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command latches, shift counter, result capture, and the done pulse.
  // done is registered off the CAPTURE state, so it rises in the first IDLE
  // cycle together with the newly captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      dir_q     <= 1'b0;
      remaining <= '0;
      result    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            data_q    <= cmd_data;
            dir_q     <= cmd_dir;
            remaining <= count_clamped;
          end
        end

        SHIFT: begin
          if (remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
          end
        end

        CAPTURE: begin
          result <= q_in;
          done   <= 1'b1;
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// tb_usr_shift_sequencer
//
// Directed bench for usr_shift_sequencer. A small zero-fill model of the usr
// closes the loop from ctrl/d back to q_in. A table of commands with
// hand-computed results is applied in a loop. Hand-written sequences cover
// reset, back-to-back issue in the done cycle, and reset mid-command.

module tb_usr_shift_sequencer;

  localparam int N     = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [N-1:0]     cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic [1:0]       ctrl;
  logic [N-1:0]     d;
  logic [N-1:0]     q_in;
  logic [N-1:0]     result;
  logic             busy;
  logic             done;

  logic [N-1:0]     usrQ;
  logic [N-1:0]     lastResult;
  int               vectors;
  int               miscompares;
  int               traceCycle;

  typedef struct {
    logic [N-1:0]     data;
    logic             dir;
    logic [CNT_W-1:0] count;
    int               nShift;
    logic [N-1:0]     expResult;
  } vec_t;

  vec_t vecs[7];

  usr_shift_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .ctrl      (ctrl),
    .d         (d),
    .q_in      (q_in),
    .result    (result),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-fill universal shift register model; it has no reset of its own.
  initial usrQ = '0;
  always_ff @(posedge clk) begin
    case (ctrl)
      2'b01:   usrQ <= usrQ >> 1;
      2'b10:   usrQ <= usrQ << 1;
      2'b11:   usrQ <= d;
      default: usrQ <= usrQ;
    endcase
  end
  assign q_in = usrQ;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s (trace cycle %0d): got %0h, expected %0h",
               name, traceCycle, actual, expected);
    end
  endtask

  // Present a command in the second half of an IDLE cycle and hold it
  // through the accepting edge.
  task automatic applyStimulus(input logic [N-1:0] data, input logic dir,
                               input logic [CNT_W-1:0] count);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = data;
    cmd_dir   = dir;
    cmd_count = count;
    traceCycle = -1;
    checkOutput("ready_before_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Follow one command from its LOAD cycle to its done cycle. cmd_* are
  // scrambled while busy; the sequence must still match the accepted
  // command. The task returns at the negedge of the done cycle.
  task automatic runTrace(input logic [N-1:0] data, input logic dir,
                          input int nShift, input logic [N-1:0] expResult);
    logic [1:0] expCtrl;
    for (int i = 0; i <= nShift + 2; i++) begin
      @(negedge clk);
      traceCycle = i;
      if (i == 0)           expCtrl = 2'b11;
      else if (i <= nShift) expCtrl = dir ? 2'b10 : 2'b01;
      else                  expCtrl = 2'b00;
      checkOutput("ctrl", 32'(ctrl), 32'(expCtrl));
      checkOutput("busy", 32'(busy), (i <= nShift + 1) ? 32'd1 : 32'd0);
      checkOutput("done", 32'(done), (i == nShift + 2) ? 32'd1 : 32'd0);
      checkOutput("cmd_ready", 32'(cmd_ready), (i == nShift + 2) ? 32'd1 : 32'd0);
      if (i <= nShift) checkOutput("d", 32'(d), 32'(data));
      if (i == 0) checkOutput("result_hold", 32'(result), 32'(lastResult));
      if (i == nShift + 2) begin
        checkOutput("result", 32'(result), 32'(expResult));
        lastResult = expResult;
      end else begin
        cmd_data  = 8'($urandom);
        cmd_dir   = 1'($urandom_range(0, 1));
        cmd_count = 4'($urandom_range(0, 15));
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    traceCycle  = -1;
    lastResult  = '0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_dir     = 1'b0;
    cmd_data    = '0;
    cmd_count   = '0;

    // data, dir, count, shift cycles, hand-computed result
    vecs[0] = '{8'hB4, 1'b0, 4'd3,  3, 8'h16};
    vecs[1] = '{8'hFF, 1'b0, 4'd12, 8, 8'h00};
    vecs[2] = '{8'hA5, 1'b1, 4'd1,  1, 8'h4A};
    vecs[3] = '{8'hE7, 1'b1, 4'd4,  4, 8'h70};
    vecs[4] = '{8'h6D, 1'b0, 4'd5,  5, 8'h03};
    vecs[5] = '{8'h80, 1'b1, 4'd0,  0, 8'h80};
    vecs[6] = '{8'hC9, 1'b1, 4'd15, 8, 8'h00};

    // Reset held for two edges, then the idle state is checked.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("ready_in_reset", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ctrl",   32'(ctrl),      32'd0);
    checkOutput("reset_d",      32'(d),         32'd0);
    checkOutput("reset_result", 32'(result),    32'd0);
    checkOutput("reset_done",   32'(done),      32'd0);
    checkOutput("reset_busy",   32'(busy),      32'd0);
    checkOutput("reset_ready",  32'(cmd_ready), 32'd1);

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].data, vecs[v].dir, vecs[v].count);
      runTrace(vecs[v].data, vecs[v].dir, vecs[v].nShift, vecs[v].expResult);
    end

    // Left shift by 2, then a count-0 command issued in the done cycle.
    applyStimulus(8'h81, 1'b1, 4'd2);
    runTrace(8'h81, 1'b1, 2, 8'h04);
    cmd_valid = 1'b1;
    cmd_data  = 8'h5A;
    cmd_dir   = 1'b0;
    cmd_count = 4'd0;
    checkOutput("b2b_ready_in_done", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    runTrace(8'h5A, 1'b0, 0, 8'h5A);

    // Reset asserted during the third SHIFT cycle of a 6-shift command.
    applyStimulus(8'hC3, 1'b0, 4'd6);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      traceCycle = i;
      checkOutput("abort_ctrl", 32'(ctrl), (i == 0) ? 32'd3 : 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    traceCycle = -1;
    checkOutput("abort_ctrl_after",   32'(ctrl),      32'd0);
    checkOutput("abort_busy_after",   32'(busy),      32'd0);
    checkOutput("abort_done_after",   32'(done),      32'd0);
    checkOutput("abort_result_clear", 32'(result),    32'd0);
    checkOutput("abort_ready_in_rst", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    lastResult = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      traceCycle = i;
      checkOutput("abort_no_done", 32'(done), 32'd0);
    end
    applyStimulus(8'h3C, 1'b1, 4'd1);
    runTrace(8'h3C, 1'b1, 1, 8'h78);

    // done must fall back after its single cycle.
    @(negedge clk);
    traceCycle = -1;
    checkOutput("done_single_cycle", 32'(done), 32'd0);
    checkOutput("result_holds", 32'(result), 32'h78);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
